inemo_seq_ctrl: RTL and testbench

Sequencer for the 6-axis iNEMO inertial sensor on the SPI bus.
- After power-up it waits out the sensor's POR window, checks WHO_AM_I and writes the configuration registers.
- On each sensor INT it reads all 12 data bytes and presents six 16-bit readings atomically with a valid pulse.
- It drives the existing SPI monarch through its wrt/done handshake and sits between that monarch and the inertial integrator.

---
 rtl/inemo_pkg.sv | 30 +++
 rtl/inemo_seq_ctrl_if.sv | 11 +
 rtl/inemo_frame_buf.sv | 49 ++++
 rtl/inemo_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_inemo_seq_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/inemo_pkg.sv
// Shared types and constants for the iNEMO sequencer: FSM states, config table, register map.
// No logic here; latency and backpressure are defined by the modules that import it.
package inemo_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT,
    ID_RD,
    CFG,
    IDLE,
    RD,
    LOAD,
    ERR
  } state_t;

  localparam logic [6:0] WHO_AM_I_ADDR  = 7'h0F;
  localparam logic [7:0] WHO_AM_I_VAL   = 8'h6A;
  localparam logic [6:0] DATA_BASE_ADDR = 7'h22;
  localparam int         NUM_DATA_BYTES = 12;
  localparam int         NUM_CFG        = 4;

  // Write commands {R/Wn=0, addr, data}, issued in index order.
  localparam logic [0:NUM_CFG-1][15:0] CFG_TBL = {
    16'h0D02, 16'h1053, 16'h1160, 16'h1440
  };

  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

endpackage

// File: rtl/inemo_seq_ctrl_if.sv
// SPI monarch handshake bundle: one wrt pulse per transaction, done pulse on completion.
// Single outstanding transaction; the master holds cmd from wrt until done.
interface inemo_seq_ctrl_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inemo_frame_buf.sv
// Staging array for the 12 sensor data bytes plus the six axis output registers.
// Byte write is 1 clk; load copies all staged bytes to the outputs in one clk, no backpressure.
module inemo_frame_buf
  import inemo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [3:0]  idx_i,
  input  logic [7:0]  byte_i,
  input  logic        load_i,
  output logic [15:0] ptch_rt_o,
  output logic [15:0] roll_rt_o,
  output logic [15:0] yaw_rt_o,
  output logic [15:0] ax_o,
  output logic [15:0] ay_o,
  output logic [15:0] az_o
);

  logic [7:0] stage_q [NUM_DATA_BYTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DATA_BYTES; i++) stage_q[i] <= 8'h00;
    end else if (wr_en_i && (idx_i < 4'(NUM_DATA_BYTES))) begin
      stage_q[idx_i] <= byte_i;
    end
  end

  // Sensor registers are little-endian: even address is the low byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_rt_o <= 16'h0000;
      roll_rt_o <= 16'h0000;
      yaw_rt_o  <= 16'h0000;
      ax_o      <= 16'h0000;
      ay_o      <= 16'h0000;
      az_o      <= 16'h0000;
    end else if (load_i) begin
      ptch_rt_o <= {stage_q[1],  stage_q[0]};
      roll_rt_o <= {stage_q[3],  stage_q[2]};
      yaw_rt_o  <= {stage_q[5],  stage_q[4]};
      ax_o      <= {stage_q[7],  stage_q[6]};
      ay_o      <= {stage_q[9],  stage_q[8]};
      az_o      <= {stage_q[11], stage_q[10]};
    end
  end

endmodule

// File: rtl/inemo_seq_ctrl.sv
// iNEMO sequencer: startup wait, WHO_AM_I check, config writes, then one 12-byte frame per INT.
// One SPI transaction outstanding, >=1 idle clk after done; vld pulses 1 clk after the last done is sampled.
module inemo_seq_ctrl
  import inemo_pkg::*;
#(
  parameter int STARTUP_CYCLES = 65535,
  parameter int ID_RETRIES     = 4
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     INT,
  inemo_seq_ctrl_if.master         spi,
  output logic [15:0]              ptch_rt,
  output logic [15:0]              roll_rt,
  output logic [15:0]              yaw_rt,
  output logic [15:0]              ax,
  output logic [15:0]              ay,
  output logic [15:0]              az,
  output logic                     vld,
  output logic                     nemo_rdy,
  output logic                     id_err
);

  localparam int TW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int RW = $clog2(ID_RETRIES + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(STARTUP_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(ID_RETRIES - 1);
  localparam logic [3:0]    CFG_LAST   = 4'(NUM_CFG - 1);
  localparam logic [3:0]    RD_LAST    = 4'(NUM_DATA_BYTES - 1);
  localparam logic [15:0]   ID_CMD     = {1'b1, WHO_AM_I_ADDR, 8'h00};

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [RW-1:0] retry_q;
  logic [3:0]    idx_q;
  logic          busy_q;
  logic          wrt_q;
  logic [15:0]   cmd_q;
  logic          vld_q;
  logic          nemo_rdy_q;
  logic          id_err_q;
  logic          int_meta_q;
  logic          int_sync_q;

  logic          done_acc;
  logic          issue_vld_d;
  logic [15:0]   issue_cmd_d;
  logic          unused_rd_hi;

  // A done with nothing outstanding is a stray and must not advance the sequence.
  assign done_acc     = busy_q & spi.done;
  assign unused_rd_hi = ^spi.rd_data[15:8];

  // busy_q clears on the done edge, so the earliest reissue leaves one idle clk.
  always_comb begin
    issue_vld_d = 1'b0;
    issue_cmd_d = ID_CMD;
    case (state_q)
      INIT_WAIT: issue_vld_d = (timer_q == TIMER_LAST);
      ID_RD:     issue_vld_d = !busy_q;
      CFG: begin
        issue_vld_d = !busy_q;
        issue_cmd_d = CFG_TBL[idx_q[1:0]];
      end
      RD: begin
        issue_vld_d = !busy_q;
        issue_cmd_d = rd_cmd(DATA_BASE_ADDR + {3'b000, idx_q});
      end
      default: issue_vld_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT_WAIT;
      timer_q    <= '0;
      retry_q    <= '0;
      idx_q      <= 4'h0;
      busy_q     <= 1'b0;
      wrt_q      <= 1'b0;
      cmd_q      <= 16'h0000;
      vld_q      <= 1'b0;
      nemo_rdy_q <= 1'b0;
      id_err_q   <= 1'b0;
      int_meta_q <= 1'b0;
      int_sync_q <= 1'b0;
    end else begin
      int_meta_q <= INT;
      int_sync_q <= int_meta_q;
      wrt_q      <= 1'b0;
      vld_q      <= 1'b0;

      if (done_acc) busy_q <= 1'b0;

      if (issue_vld_d) begin
        wrt_q  <= 1'b1;
        cmd_q  <= issue_cmd_d;
        busy_q <= 1'b1;
      end

      case (state_q)
        INIT_WAIT: begin
          if (timer_q == TIMER_LAST) state_q <= ID_RD;
          else                       timer_q <= timer_q + TW'(1);
        end
        ID_RD: begin
          if (done_acc) begin
            if (spi.rd_data[7:0] == WHO_AM_I_VAL) begin
              state_q <= CFG;
              idx_q   <= 4'h0;
            end else begin
              retry_q <= retry_q + RW'(1);
              if (retry_q == RETRY_LAST) begin
                id_err_q <= 1'b1;
                state_q  <= ERR;
              end
            end
          end
        end
        CFG: begin
          if (done_acc) begin
            if (idx_q == CFG_LAST) begin
              nemo_rdy_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              idx_q <= idx_q + 4'h1;
            end
          end
        end
        IDLE: begin
          if (int_sync_q) begin
            state_q <= RD;
            idx_q   <= 4'h0;
          end
        end
        RD: begin
          if (done_acc) begin
            if (idx_q == RD_LAST) state_q <= LOAD;
            else                  idx_q   <= idx_q + 4'h1;
          end
        end
        LOAD: begin
          vld_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= ERR;
      endcase
    end
  end

  inemo_frame_buf u_frame_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   ((state_q == RD) && done_acc),
    .idx_i     (idx_q),
    .byte_i    (spi.rd_data[7:0]),
    .load_i    (state_q == LOAD),
    .ptch_rt_o (ptch_rt),
    .roll_rt_o (roll_rt),
    .yaw_rt_o  (yaw_rt),
    .ax_o      (ax),
    .ay_o      (ay),
    .az_o      (az)
  );

  assign spi.wrt  = wrt_q;
  assign spi.cmd  = cmd_q;
  assign vld      = vld_q;
  assign nemo_rdy = nemo_rdy_q;
  assign id_err   = id_err_q;

endmodule

// File: tb/tb_inemo_seq_ctrl.sv
// Directed bench for inemo_seq_ctrl: startup, WHO_AM_I retries, config, frames, mid-frame reset.
// Acts as the SPI monarch and sensor; short startup window keeps the run small.
module tb_inemo_seq_ctrl;

  localparam int S = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sens_int;
  logic [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay, az;
  logic        vld, nemo_rdy, id_err;

  int n_assert = 0;
  int n_fail   = 0;

  inemo_seq_ctrl_if spi();

  inemo_seq_ctrl #(.STARTUP_CYCLES(S), .ID_RETRIES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .INT      (sens_int),
    .spi      (spi),
    .ptch_rt  (ptch_rt),
    .roll_rt  (roll_rt),
    .yaw_rt   (yaw_rt),
    .ax       (ax),
    .ay       (ay),
    .az       (az),
    .vld      (vld),
    .nemo_rdy (nemo_rdy),
    .id_err   (id_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] p, input logic [15:0] r,
                            input logic [15:0] y, input logic [15:0] x,
                            input logic [15:0] yy, input logic [15:0] z);
    chk16({tag, "_ptch"}, ptch_rt, p);
    chk16({tag, "_roll"}, roll_rt, r);
    chk16({tag, "_yaw"},  yaw_rt,  y);
    chk16({tag, "_ax"},   ax,      x);
    chk16({tag, "_ay"},   ay,      yy);
    chk16({tag, "_az"},   az,      z);
  endtask

  task automatic wait_wrt(input string tag, input logic [15:0] exp_cmd);
    for (int i = 0; i < 200 && !spi.wrt; i++) tick();
    chk1({tag, "_wrt"}, spi.wrt, 1'b1);
    chk16({tag, "_cmd"}, spi.cmd, exp_cmd);
  endtask

  // Sensor answers two clks after wrt; upper byte is junk the DUT must ignore.
  task automatic respond(input string tag, input logic [7:0] data, input logic [15:0] exp_cmd);
    tick();
    chk1({tag, "_pulse"}, spi.wrt, 1'b0);
    tick();
    chk16({tag, "_held"}, spi.cmd, exp_cmd);
    spi.done    = 1'b1;
    spi.rd_data = {8'hA5, data};
    tick();
    spi.done    = 1'b0;
    spi.rd_data = 16'h0000;
  endtask

  task automatic xact(input string tag, input logic [7:0] data, input logic [15:0] exp_cmd);
    wait_wrt(tag, exp_cmd);
    respond(tag, data, exp_cmd);
  endtask

  task automatic startup(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < S + 50; i++) begin
      tick();
      if (spi.wrt) break;
      n++;
    end
    chk16({tag, "_idle_clks"}, 16'(n), 16'(S - 1));
    chk16({tag, "_cmd"}, spi.cmd, 16'h8F00);
  endtask

  task automatic do_frame(input logic [95:0] b, input bit keep_int, input int nbytes);
    sens_int = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      xact($sformatf("rd%0d", i), b[8*i +: 8], 16'hA200 + 16'(i << 8));
      if (i == 0 && !keep_int) sens_int = 1'b0;
    end
  endtask

  task automatic count_wrt(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (spi.wrt) n++;
    end
    chk16(tag, 16'(n), 16'h0000);
  endtask

  localparam logic [95:0] F1 = 96'h4433_2211_DEF0_9ABC_5678_1234;
  localparam logic [95:0] F2 = 96'h0C0B_0A09_0807_0605_0403_0201;
  localparam logic [95:0] F3 = 96'h3CC3_FFFE_0001_AA55_8000_7FFF;

  initial begin
    int n;
    spi.done    = 1'b0;
    spi.rd_data = 16'h0000;
    sens_int    = 1'b0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    repeat (3) tick();

    chk1("rst_wrt", spi.wrt, 1'b0);
    chk16("rst_cmd", spi.cmd, 16'h0000);
    chk1("rst_vld", vld, 1'b0);
    chk1("rst_nemo_rdy", nemo_rdy, 1'b0);
    chk1("rst_id_err", id_err, 1'b0);
    check_outs("rst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // INT high across startup and ID must not start a frame.
    sens_int = 1'b1;
    rst_n    = 1'b1;
    startup("start1");
    respond("id1", 8'h00, 16'h8F00);
    xact("id2", 8'h00, 16'h8F00);
    xact("id3", 8'h6A, 16'h8F00);
    sens_int = 1'b0;

    xact("cfg0", 8'h00, 16'h0D02);
    sens_int = 1'b1;
    xact("cfg1", 8'h00, 16'h1053);
    sens_int = 1'b0;
    xact("cfg2", 8'h00, 16'h1160);
    wait_wrt("cfg3", 16'h1440);
    chk1("cfg3_nemo_pre", nemo_rdy, 1'b0);
    respond("cfg3", 8'h00, 16'h1440);
    chk1("cfg_nemo_rdy", nemo_rdy, 1'b1);
    chk1("cfg_id_err", id_err, 1'b0);

    spi.done = 1'b1;
    tick();
    spi.done = 1'b0;
    count_wrt("idle_no_wrt", 12);
    chk1("idle_vld", vld, 1'b0);

    do_frame(F1, 1'b0, 12);
    chk1("f1_vld_pre", vld, 1'b0);
    check_outs("f1_pre", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    chk1("f1_vld", vld, 1'b1);
    check_outs("f1", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h2211, 16'h4433);
    tick();
    chk1("f1_vld_post", vld, 1'b0);
    check_outs("f1_hold", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h2211, 16'h4433);
    count_wrt("f1_single", 10);

    // INT held high: second frame follows straight out of LOAD.
    do_frame(F2, 1'b1, 12);
    tick();
    chk1("f2_vld", vld, 1'b1);
    check_outs("f2", 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'h0C0B);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (spi.wrt) break;
    end
    chk16("b2b_gap", 16'(n), 16'd2);
    do_frame(F3, 1'b0, 12);
    check_outs("f3_pre", 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'h0C0B);
    tick();
    chk1("f3_vld", vld, 1'b1);
    check_outs("f3", 16'h7FFF, 16'h8000, 16'hAA55, 16'h0001, 16'hFFFE, 16'h3CC3);
    count_wrt("f3_no_more", 20);

    // Reset while the 6th read's wrt is high.
    do_frame(F1, 1'b0, 5);
    wait_wrt("rd5", 16'hA700);
    rst_n = 1'b0;
    #1;
    chk1("mrst_wrt", spi.wrt, 1'b0);
    chk16("mrst_cmd", spi.cmd, 16'h0000);
    chk1("mrst_nemo_rdy", nemo_rdy, 1'b0);
    check_outs("mrst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    startup("start2");

    respond("idf1", 8'h00, 16'h8F00);
    xact("idf2", 8'h00, 16'h8F00);
    xact("idf3", 8'h00, 16'h8F00);
    chk1("idf3_id_err", id_err, 1'b0);
    xact("idf4", 8'h00, 16'h8F00);
    chk1("idf4_id_err", id_err, 1'b1);
    chk1("idf4_nemo_rdy", nemo_rdy, 1'b0);
    sens_int = 1'b1;
    count_wrt("err_no_wrt", 30);
    chk1("err_id_err_sticky", id_err, 1'b1);
    sens_int = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
